// File: rtl/usrp_tag_chip_mrx_ctrl.sv
// Receive-side framer/integrator for the tag-chip matrix measurement.
// Optional pilot-interval integration is enabled by defining MRX_PILOT_ACC_EN.
module usrp_tag_chip_mrx_ctrl #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned PHASE_WIDTH = 24,
    parameter int unsigned NSYMB_WIDTH = 16,
    parameter int unsigned REG_WIDTH   = 12,
    parameter int unsigned ACC_WIDTH   = 32,
    parameter int unsigned NSIG        = 8192,
    parameter int unsigned PILOT_NSIG  = 65536,
    parameter int unsigned NSYMB       = 24,
    parameter int unsigned TRIG_BIT    = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [REG_WIDTH-1:0]   fp_gpio_in,
    output logic [REG_WIDTH-1:0]   fp_gpio_ddr,
    input  logic [DATA_WIDTH-1:0]  irx,
    input  logic [DATA_WIDTH-1:0]  qrx,
    input  logic                   rx_valid,
    output logic                   busy,
    output logic                   pilot_active,
    output logic [NSYMB_WIDTH-1:0] rx_symbN,
    output logic [PHASE_WIDTH-1:0] rx_sigN,
    output logic [ACC_WIDTH-1:0]   iacc,
    output logic [ACC_WIDTH-1:0]   qacc,
    output logic                   acc_valid,
    output logic [NSYMB_WIDTH-1:0] acc_symbN,
    output logic                   frame_done,
    output logic                   trig_overrun
);

    localparam logic [PHASE_WIDTH-1:0] SIG_LAST   = PHASE_WIDTH'(NSIG - 1);
    localparam logic [PHASE_WIDTH-1:0] PILOT_LAST = PHASE_WIDTH'(PILOT_NSIG - 1);
    localparam logic [NSYMB_WIDTH-1:0] SYMB_LAST  = NSYMB_WIDTH'(NSYMB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PILOT,
        S_SYMB
    } state_t;

    state_t               state;
    logic [2:0]           sync;
    logic                 trig_rise;
    logic [ACC_WIDTH-1:0] run_i;
    logic [ACC_WIDTH-1:0] run_q;
    logic [ACC_WIDTH-1:0] sum_i;
    logic [ACC_WIDTH-1:0] sum_q;
    logic                 unused_gpio;

    // Only TRIG_BIT matters; the remaining pins are inputs that nothing reads.
    assign fp_gpio_ddr = '0;
    assign unused_gpio = ^fp_gpio_in;

    assign trig_rise = sync[1] & ~sync[2];
    assign sum_i     = run_i + ACC_WIDTH'($signed(irx));
    assign sum_q     = run_q + ACC_WIDTH'($signed(qrx));

    // Two synchronizer flops plus one history flop for the edge detector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], fp_gpio_in[TRIG_BIT]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            pilot_active <= 1'b0;
            rx_symbN     <= '0;
            rx_sigN      <= '0;
            run_i        <= '0;
            run_q        <= '0;
            iacc         <= '0;
            qacc         <= '0;
            acc_valid    <= 1'b0;
            acc_symbN    <= '0;
            frame_done   <= 1'b0;
            trig_overrun <= 1'b0;
        end else begin
            acc_valid  <= 1'b0;
            frame_done <= 1'b0;

            // The frame_done cycle still counts as busy for a new sync edge.
            if (trig_rise && (state != S_IDLE || frame_done)) begin
                trig_overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (trig_rise && !frame_done) begin
                        state        <= S_PILOT;
                        busy         <= 1'b1;
                        pilot_active <= 1'b1;
                        rx_sigN      <= '0;
                        rx_symbN     <= '0;
                        run_i        <= '0;
                        run_q        <= '0;
                    end
                end

                S_PILOT: begin
                    if (rx_valid) begin
`ifdef MRX_PILOT_ACC_EN
                        run_i <= sum_i;
                        run_q <= sum_q;
`endif
                        if (rx_sigN == PILOT_LAST) begin
                            state        <= S_SYMB;
                            pilot_active <= 1'b0;
                            rx_sigN      <= '0;
                            rx_symbN     <= '0;
`ifdef MRX_PILOT_ACC_EN
                            iacc         <= sum_i;
                            qacc         <= sum_q;
                            acc_valid    <= 1'b1;
                            acc_symbN    <= '1;
                            run_i        <= '0;
                            run_q        <= '0;
`endif
                        end else begin
                            rx_sigN <= rx_sigN + PHASE_WIDTH'(1);
                        end
                    end
                end

                S_SYMB: begin
                    if (rx_valid) begin
                        if (rx_sigN == SIG_LAST) begin
                            iacc      <= sum_i;
                            qacc      <= sum_q;
                            acc_valid <= 1'b1;
                            acc_symbN <= rx_symbN;
                            run_i     <= '0;
                            run_q     <= '0;
                            rx_sigN   <= '0;
                            if (rx_symbN == SYMB_LAST) begin
                                state      <= S_IDLE;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                                rx_symbN   <= '0;
                            end else begin
                                rx_symbN <= rx_symbN + NSYMB_WIDTH'(1);
                            end
                        end else begin
                            run_i   <= sum_i;
                            run_q   <= sum_q;
                            rx_sigN <= rx_sigN + PHASE_WIDTH'(1);
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usrp_tag_chip_mrx_ctrl.sv
// Randomized/directed bench for usrp_tag_chip_mrx_ctrl against a sample-count reference model.
module tb_usrp_tag_chip_mrx_ctrl;

    localparam int unsigned DW = 16, PW = 24, SW = 16, RW = 12, AW = 32;
    localparam int NSIG = 4, PN = 8, NS = 3;
`ifdef MRX_PILOT_ACC_EN
    localparam bit PACC = 1'b1;
`else
    localparam bit PACC = 1'b0;
`endif

    logic          clk, reset_n, rx_valid;
    logic [RW-1:0] fp_gpio_in, fp_gpio_ddr;
    logic [DW-1:0] irx, qrx;
    logic          busy, pilot_active, acc_valid, frame_done, trig_overrun;
    logic [SW-1:0] rx_symbN, acc_symbN;
    logic [PW-1:0] rx_sigN;
    logic [AW-1:0] iacc, qacc;

    usrp_tag_chip_mrx_ctrl #(
        .DATA_WIDTH(DW), .PHASE_WIDTH(PW), .NSYMB_WIDTH(SW), .REG_WIDTH(RW),
        .ACC_WIDTH(AW), .NSIG(NSIG), .PILOT_NSIG(PN), .NSYMB(NS), .TRIG_BIT(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .fp_gpio_in(fp_gpio_in), .fp_gpio_ddr(fp_gpio_ddr),
        .irx(irx), .qrx(qrx), .rx_valid(rx_valid), .busy(busy), .pilot_active(pilot_active),
        .rx_symbN(rx_symbN), .rx_sigN(rx_sigN), .iacc(iacc), .qacc(qacc), .acc_valid(acc_valid),
        .acc_symbN(acc_symbN), .frame_done(frame_done), .trig_overrun(trig_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a frame is just a count of accepted samples since the trigger.
    bit            m_active, m_ovr, m_av, m_fd;
    int            m_cnt, m_si, m_sq;
    logic [AW-1:0] m_iacc, m_qacc;
    logic [SW-1:0] m_symb;
    bit            h0, h1, h2;

    int            sym_steps[$];
    logic [AW-1:0] sym_iacc[$];
    logic [AW-1:0] sym_qacc[$];
    logic [AW-1:0] pil_iacc, pil_qacc;
    int            pil_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_active = 0; m_ovr = 0; m_av = 0; m_fd = 0;
        m_cnt = 0; m_si = 0; m_sq = 0;
        m_iacc = '0; m_qacc = '0; m_symb = '0;
        h0 = 0; h1 = 0; h2 = 0;
    endtask

    task automatic model_dump(input logic [SW-1:0] sym);
        m_iacc = AW'(m_si);
        m_qacc = AW'(m_sq);
        m_symb = sym;
        m_av   = 1;
        m_si   = 0;
        m_sq   = 0;
    endtask

    task automatic model_edge(input bit v, input int i, input int q, input bit g);
        bit rise, was_active, fd_prev;
        int k;
        rise = h1 & ~h2;
        h2 = h1; h1 = h0; h0 = g;
        was_active = m_active;
        fd_prev = m_fd;
        m_av = 0;
        m_fd = 0;
        if (was_active && v) begin
            if (m_cnt < PN) begin
                if (PACC) begin
                    m_si += i;
                    m_sq += q;
                    if (m_cnt == PN - 1) model_dump('1);
                end
            end else begin
                m_si += i;
                m_sq += q;
                k = m_cnt - PN;
                if (k % NSIG == NSIG - 1) begin
                    model_dump(SW'(k / NSIG));
                    if (k / NSIG == NS - 1) begin
                        m_fd = 1;
                        m_active = 0;
                    end
                end
            end
            m_cnt++;
        end
        if (rise) begin
            if (was_active || fd_prev) m_ovr = 1;
            else begin
                m_active = 1; m_cnt = 0; m_si = 0; m_sq = 0;
            end
        end
    endtask

    task automatic check_all();
        int esig, esym;
        esig = 0; esym = 0;
        if (m_active) begin
            if (m_cnt < PN) esig = m_cnt;
            else begin
                esig = (m_cnt - PN) % NSIG;
                esym = (m_cnt - PN) / NSIG;
            end
        end
        chk("busy", 64'(busy), 64'(m_active));
        chk("pilot_active", 64'(pilot_active), 64'(m_active && m_cnt < PN));
        chk("rx_sigN", 64'(rx_sigN), 64'(esig));
        chk("rx_symbN", 64'(rx_symbN), 64'(esym));
        chk("acc_valid", 64'(acc_valid), 64'(m_av));
        chk("frame_done", 64'(frame_done), 64'(m_fd));
        chk("trig_overrun", 64'(trig_overrun), 64'(m_ovr));
        chk("iacc", 64'(iacc), 64'(m_iacc));
        chk("qacc", 64'(qacc), 64'(m_qacc));
        chk("acc_symbN", 64'(acc_symbN), 64'(m_symb));
        chk("fp_gpio_ddr", 64'(fp_gpio_ddr), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_pilot"}, 64'(pilot_active), 64'd0);
        chk({tag, "_av"}, 64'(acc_valid), 64'd0);
        chk({tag, "_fd"}, 64'(frame_done), 64'd0);
        chk({tag, "_ovr"}, 64'(trig_overrun), 64'd0);
        chk({tag, "_symb"}, 64'(rx_symbN), 64'd0);
        chk({tag, "_sig"}, 64'(rx_sigN), 64'd0);
        chk({tag, "_iacc"}, 64'(iacc), 64'd0);
        chk({tag, "_qacc"}, 64'(qacc), 64'd0);
        chk({tag, "_accsymb"}, 64'(acc_symbN), 64'd0);
        chk({tag, "_ddr"}, 64'(fp_gpio_ddr), 64'd0);
    endtask

    task automatic step(input bit v, input logic [DW-1:0] i, input logic [DW-1:0] q, input bit g);
        rx_valid   = v;
        irx        = i;
        qrx        = q;
        fp_gpio_in = {RW'($urandom) >> 1, g};
        @(posedge clk);
        model_edge(v, int'($signed(i)), int'($signed(q)), g);
        #1;
        check_all();
    endtask

    task automatic do_reset(input string tag);
        #2 reset_n = 1'b0;
        #1 check_zero({tag, "_async"});
        repeat (5) begin
            rx_valid   = 1'($urandom);
            irx        = DW'($urandom);
            qrx        = DW'($urandom);
            fp_gpio_in = RW'($urandom);
            @(posedge clk);
            #1 check_zero(tag);
        end
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // mode 0: irx=1,qrx=-2 continuous; 1: valid every other cycle, irx=SYMB sample index; 2: random.
    task automatic drive_frame(input int mode, input bit ov);
        int k, lat;
        bit seen, done, ov_done, v, g;
        logic [DW-1:0] i, q;
        k = 0; lat = -1; seen = 0; done = 0; ov_done = 0;
        sym_steps.delete(); sym_iacc.delete(); sym_qacc.delete();
        pil_seen = 0;
        repeat (4) step(1'b0, '0, '0, 1'b0);
        while (!done && k < 200) begin
            g = (k < 4);
            if (ov && !ov_done && m_active && m_cnt >= PN && (m_cnt - PN) / NSIG == 1) begin
                g = 1; ov_done = 1;
            end
            if (mode == 2 && k >= 4 && $urandom_range(15) == 0) g = 1;
            case (mode)
                0: begin v = 1; i = DW'(1); q = DW'(-2); end
                1: begin
                    v = (k % 2 == 0);
                    i = (m_active && m_cnt >= PN) ? DW'(m_cnt - PN) : '0;
                    q = DW'(-2);
                end
                default: begin
                    v = ($urandom_range(3) != 0);
                    i = DW'($urandom);
                    q = DW'($urandom);
                end
            endcase
            step(v, i, q, g);
            k++;
            if (busy && lat < 0) lat = k;
            if (acc_valid) begin
                if (acc_symbN == '1) begin
                    pil_seen++; pil_iacc = iacc; pil_qacc = qacc;
                end else begin
                    sym_steps.push_back(k); sym_iacc.push_back(iacc); sym_qacc.push_back(qacc);
                end
            end
            if (m_active) seen = 1;
            else if (seen) done = 1;
        end
        chk("frame_end", 64'(done), 64'd1);
        if (mode < 2) begin
            chk("trig_latency", 64'(lat), 64'd3);
            chk("sym_strobes", 64'(sym_steps.size()), 64'(NS));
            chk("pilot_strobes", 64'(pil_seen), 64'(PACC));
            chk("frame_done_last", 64'(frame_done), 64'd1);
            for (int j = 0; j < sym_steps.size(); j++) begin
                chk("sym_iacc", 64'(sym_iacc[j]), (mode == 0) ? 64'd4 : 64'(6 + 16 * j));
                chk("sym_qacc", 64'(sym_qacc[j]), (mode == 0) ? 64'hFFFF_FFF8 : 64'hFFFF_FFF8);
                if (j > 0)
                    chk("strobe_gap", 64'(sym_steps[j] - sym_steps[j-1]), (mode == 0) ? 64'd4 : 64'd8);
            end
            if (PACC && pil_seen > 0 && mode == 0) begin
                chk("pilot_iacc", 64'(pil_iacc), 64'd8);
                chk("pilot_qacc", 64'(pil_qacc), 64'hFFFF_FFF0);
            end
        end
    endtask

    initial begin
        int n;
        reset_n    = 1'b0;
        rx_valid   = 1'($urandom);
        irx        = DW'($urandom);
        qrx        = DW'($urandom);
        fp_gpio_in = RW'($urandom);
        model_clear();
        #1 check_zero("reset_init");
        do_reset("reset");

        drive_frame(0, 1'b0);
        drive_frame(1, 1'b0);

        drive_frame(0, 1'b1);
        chk("overrun_set", 64'(trig_overrun), 64'd1);
        repeat (6) step(1'b1, DW'($urandom), DW'($urandom), 1'b0);
        chk("overrun_sticky", 64'(trig_overrun), 64'd1);

        // Mid-frame reset: trigger, get a few samples into the pilot, then reset.
        n = 0;
        while (!(m_active && m_cnt >= 3) && n < 20) begin
            step(1'b1, DW'(1), DW'(-2), 1'b1);
            n++;
        end
        chk("in_pilot", 64'(pilot_active), 64'd1);
        do_reset("midreset");
        drive_frame(0, 1'b0);

        repeat (4) drive_frame(2, 1'b0);
        repeat (8) step(1'b1, DW'($urandom), DW'($urandom), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usrp_tag_chip_mrx_ctrl.md
# usrp_tag_chip_mrx_ctrl

Receive-side controller for the tag-chip matrix measurement; the counterpart to the transmit controller that emits the pilot tone and the NSYMB tone symbols. It waits for the transmitter's sync edge on a front-panel GPIO line, then frames the incoming baseband stream into the same pilot interval and NSYMB symbols of NSIG samples. It integrates I and Q over each symbol and emits one accumulated pair per symbol to the downstream estimator.

## Interface
- DATA_WIDTH, 16: I/Q sample width, two's complement.
- PHASE_WIDTH, 24: width of sample counters.
- NSYMB_WIDTH, 16: width of symbol counter.
- REG_WIDTH, 12: front-panel GPIO width.
- ACC_WIDTH, 32: accumulator width; must be ≥ DATA_WIDTH + clog2(max(NSIG, PILOT_NSIG)).
- NSIG, 8192: samples per symbol.
- PILOT_NSIG, 65536: samples in the pilot interval.
- NSYMB, 24: symbols per frame.
- TRIG_BIT, 0: fp_gpio_in bit carrying the transmitter sync.

Ports:
- clk  in  1  sample clock.
- reset_n  in  1  asynchronous, active-low reset.
- fp_gpio_in  in  REG_WIDTH  front-panel inputs; only TRIG_BIT is used.
- fp_gpio_ddr  out  REG_WIDTH  constant all-zero (all pins inputs).
- irx, qrx  in  DATA_WIDTH  received samples.
- rx_valid  in  1  sample qualifier.
- busy  out  1  frame in progress (PILOT or SYMB).
- pilot_active  out  1  in PILOT state.
- rx_symbN  out  NSYMB_WIDTH  current symbol index.
- rx_sigN  out  PHASE_WIDTH  current sample index within pilot or symbol.
- iacc, qacc  out  ACC_WIDTH  per-symbol sums.
- acc_valid  out  1  one-cycle strobe; iacc/qacc/acc_symbN are valid.
- acc_symbN  out  NSYMB_WIDTH  symbol index of the strobed sums.
- frame_done  out  1  one-cycle strobe at end of frame.
- trig_overrun  out  1  sticky; set by a sync edge while busy.

## Operation
- The GPIO sync passes through a 2-flop synchronizer followed by a rising-edge detector (`trig_rise`).
- States: IDLE, PILOT, SYMB.
  - IDLE: on trig_rise, go to PILOT; clear counters and accumulators.
  - PILOT: each rx_valid sample increments rx_sigN. On the sample with rx_sigN == PILOT_NSIG-1, go to SYMB with rx_sigN=0 and rx_symbN=0.
  - SYMB: each rx_valid sample adds sign-extended irx/qrx into the running sums and increments rx_sigN.
    - On the sample with rx_sigN == NSIG-1: dump the sums, including that sample, to iacc/qacc; assert acc_valid; set acc_symbN=rx_symbN. The running sums restart from zero on the next sample, with no lost sample. rx_sigN wraps to 0 and rx_symbN increments.
    - After symbol NSYMB-1 is dumped: pulse frame_done and return to IDLE.
- Samples with rx_valid low are ignored; counters and sums hold.
- trig_rise while busy is not restarted: the frame continues and trig_overrun is set. trig_overrun clears only on reset.
- trig_rise in the same cycle that frame_done is issued is treated as busy: it sets overrun and no new frame starts.
- Arithmetic: the accumulator is two's-complement wrap-around. No saturation is needed given the ACC_WIDTH rule.

## Timing
- Reset values: busy, pilot_active, acc_valid, frame_done, trig_overrun = 0; rx_symbN, rx_sigN, iacc, qacc, acc_symbN = 0; fp_gpio_ddr = 0.
- GPIO rise to busy=1: 3 clk cycles (2 sync cycles + 1 edge-register cycle).
- acc_valid is asserted in the cycle after the final valid sample of a symbol. iacc/qacc hold their value until the next dump.
- frame_done coincides with the last acc_valid. busy drops in the same cycle.
- Back-to-back symbols with continuous rx_valid: acc_valid every NSIG cycles.
- reset_n asserted mid-frame: immediate return to IDLE with all outputs at reset values, regardless of clk.

## Configuration
- MRX_PILOT_ACC_EN defined:
  - The pilot interval is also integrated.
  - At PILOT→SYMB, an acc_valid strobe is issued with acc_symbN = all ones, carrying the pilot I/Q sums for phase-reference use.
- MRX_PILOT_ACC_EN undefined: pilot samples are counted only; no pilot strobe is emitted.

## Test plan
Parameters for all scenarios: NSIG=4, PILOT_NSIG=8, NSYMB=3, continuous rx_valid unless stated.

- Reset: hold reset_n=0 for 5 cycles with random inputs -> all outputs 0; fp_gpio_ddr=0.
- Nominal frame: raise fp_gpio_in[0]; irx=1, qrx=-2 throughout ->
  - busy rises 3 cycles after the GPIO rise;
  - three acc_valid strobes, 4 cycles apart, each with iacc=4, qacc=-8 and acc_symbN=0,1,2;
  - frame_done on the third strobe.
- Valid gaps: deassert rx_valid every other cycle; irx = sample index 0..11 within SYMB -> iacc = 6, 22, 38; strobes 8 cycles apart.
- Overrun: second GPIO rise during symbol 1 -> frame completes unchanged; trig_overrun=1 and stays set.
- Mid-frame reset: assert reset_n=0 during PILOT, then release and re-trigger -> a clean frame with sums identical to the nominal case.
- MRX_PILOT_ACC_EN: nominal stimulus -> an extra strobe before symbol 0 with acc_symbN=16'hFFFF, iacc=8, qacc=-16.
